// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage owning the PC, issuing reads to a synchronous-read
// instruction memory, buffering returned words in a small prefetch queue and presenting
// them to execute through a valid/ready handshake. Supports redirect (with flush) and halt.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   imem_en          read strobe; imem_addr is sampled by memory this cycle
//   imem_addr        read address (always equals pc)
//   imem_rdata       read data, valid the cycle after imem_en
//   ir_out, ir_pc    instruction and its address at the queue head (0 when empty)
//   ir_valid         queue non-empty
//   ir_ready         execute accepts ir_out this cycle
//   redirect         load redirect_pc, flush queue and squash the in-flight read
//   redirect_pc      new fetch address
//   halt             level; blocks new issues only
//   pc               next fetch address
//   q_count          current queue occupancy
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       imem_en,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic [31:0]                ir_out,
  output logic [ADDR_W-1:0]          ir_pc,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  input  logic                       halt,
  output logic [ADDR_W-1:0]          pc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       word;
  } entry_t;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  entry_t            store_q [DEPTH];

  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    occ;
  entry_t            head;

  // Handshake and issue decision for this cycle.
  always_comb begin
    pop   = (cnt_q != '0) & ir_ready;
    push  = infl_q & ~redirect;
    // Occupancy after this cycle's pop, counting the read already in flight.
    occ   = {1'b0, cnt_q} + (CNT_W+1)'(infl_q) - (CNT_W+1)'(pop);
    issue = (state_q == ST_RUN) & ~halt & ~redirect & (occ < (CNT_W+1)'(DEPTH));
  end

  // FSM next state; redirect never changes the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = halt ? ST_HALT : ST_RUN;
      ST_RUN:  if (halt)  state_d = ST_HALT;
      ST_HALT: if (!halt) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // Datapath next state: PC, in-flight tracking, queue pointers and count.
  always_comb begin
    pc_d      = pc_q;
    infl_d    = issue;
    infl_pc_d = infl_pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;

    if (redirect) begin
      // Flush: a handshake this cycle still completes, the consumer keeps that word.
      pc_d     = redirect_pc;
      infl_d   = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (issue) begin
        infl_pc_d = pc_q;
        pc_d      = pc_q + ADDR_W'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Queue storage needs no reset; validity is carried by cnt_q.
  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr_q] <= '{pc: infl_pc_q, word: imem_rdata};
  end

  // Output mapping; head fields are forced to zero while the queue is empty.
  always_comb begin
    head      = store_q[rd_ptr_q];
    ir_valid  = (cnt_q != '0);
    ir_out    = ir_valid ? head.word : 32'h0;
    ir_pc     = ir_valid ? head.pc   : '0;
    imem_en   = issue;
    imem_addr = pc_q;
    pc        = pc_q;
    q_count   = cnt_q;
  end

endmodule
